// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async_fifo block family.
// Contents:
//   DEFAULT_DATA_WIDTH - default word width of FIFO users
//   arb_state_e        - arbiter state encoding (ST_IDLE / ST_GRANT)
//   clog2()            - ceiling log2, used to size index and counter fields
package async_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Searches req starting at the index after 'last', wrapping modulo N, and
// returns the first requester found.
// Ports:
//   req  in  N   request vector
//   last in  IW  index of the previous winner (search starts at last+1)
//   gnt  out N   one-hot winner, 0 when no request
//   idx  out IW  index of the winner, 0 when no request
//   any  out 1   at least one request present
module rr_pick
  import async_fifo_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  assign any = |req;

  // Walk the N candidates in rotating order; the first hit latches and masks the rest.
  always_comb begin
    logic [IW-1:0] k;
    logic          hit;
    logic          found;
    gnt   = '0;
    idx   = '0;
    k     = '0;
    hit   = 1'b0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      k      = IW'((int'(last) + i) % N);
      hit    = ~found & req[k];
      gnt[k] = gnt[k] | hit;
      idx    = hit ? k : idx;
      found  = found | hit;
    end
  end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// Write-side arbiter for async_fifo: shares the single FIFO write port among
// NUM_SRC requesters with round-robin grant and bursts of at most BURST_LEN
// accepted words. Stalls (holding grant and burst count) while the FIFO is full.
// Ports:
//   fifo_w_clk_i  in  1                   write clock
//   rst_n_i       in  1                   asynchronous active-low reset
//   src_req_i     in  NUM_SRC             per-source valid
//   src_data_i    in  NUM_SRC*DATA_WIDTH  packed source data, source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   src_ack_o     out NUM_SRC             one-hot accept strobe
//   fifo_w_req_o  out 1                   FIFO write request
//   fifo_w_data_o out DATA_WIDTH          FIFO write data
//   fifo_w_full_i in  1                   FIFO full flag
//   grant_o       out NUM_SRC             one-hot current owner, 0 when idle
//   busy_o        out 1                   high while a source is granted
module async_fifo_wr_arb
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_SRC    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          fifo_w_clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_SRC-1:0]            src_req_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
  output logic [NUM_SRC-1:0]            src_ack_o,
  output logic                          fifo_w_req_o,
  output logic [DATA_WIDTH-1:0]         fifo_w_data_o,
  input  logic                          fifo_w_full_i,
  output logic [NUM_SRC-1:0]            grant_o,
  output logic                          busy_o
);

  localparam int IW = clog2(NUM_SRC);
  localparam int CW = clog2(BURST_LEN + 1);

  arb_state_e          state_r;
  logic [NUM_SRC-1:0]  grant_r;
  logic [IW-1:0]       owner_r;
  logic [IW-1:0]       last_r;
  logic [CW-1:0]       burst_cnt_r;

  logic                owner_req_s;
  logic                wr_s;
  logic                burst_end_s;
  logic [IW-1:0]       pick_last_s;
  logic [NUM_SRC-1:0]  pick_gnt_s;
  logic [IW-1:0]       pick_idx_s;
  logic                pick_any_s;
  logic [DATA_WIDTH-1:0] data_s;

  assign owner_req_s = |(grant_r & src_req_i);
  assign wr_s        = owner_req_s & ~fifo_w_full_i;
  // A full FIFO never ends a burst: wr_s is low, and the owner is still requesting.
  assign burst_end_s = (wr_s & (burst_cnt_r == CW'(BURST_LEN - 1))) | ~owner_req_s;

  // While granted, the search starts after the current owner so the hand-over
  // at burst end is already the next round-robin choice.
  assign pick_last_s = (state_r == ST_GRANT) ? owner_r : last_r;

  rr_pick #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_rr_pick (
    .req  (src_req_i),
    .last (pick_last_s),
    .gnt  (pick_gnt_s),
    .idx  (pick_idx_s),
    .any  (pick_any_s)
  );

  // AND-OR data mux; grant is one-hot or zero, so no grant yields zero data.
  always_comb begin
    data_s = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      data_s = data_s | (src_data_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_r[k]}});
    end
  end

  assign fifo_w_req_o  = owner_req_s;
  assign fifo_w_data_o = data_s;
  assign src_ack_o     = grant_r & src_req_i & {NUM_SRC{~fifo_w_full_i}};
  assign grant_o       = grant_r;
  assign busy_o        = (state_r == ST_GRANT);

  // Arbitration FSM with burst counter; grant, owner and last winner are registered.
  always_ff @(posedge fifo_w_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_IDLE;
      grant_r     <= '0;
      owner_r     <= '0;
      last_r      <= IW'(NUM_SRC - 1);
      burst_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            state_r     <= ST_GRANT;
            grant_r     <= pick_gnt_s;
            owner_r     <= pick_idx_s;
            burst_cnt_r <= '0;
          end else begin
            grant_r     <= '0;
            burst_cnt_r <= '0;
          end
        end
        ST_GRANT: begin
          if (burst_end_s) begin
            last_r      <= owner_r;
            burst_cnt_r <= '0;
            if (pick_any_s) begin
              grant_r <= pick_gnt_s;
              owner_r <= pick_idx_s;
            end else begin
              state_r <= ST_IDLE;
              grant_r <= '0;
            end
          end else if (wr_s) begin
            burst_cnt_r <= burst_cnt_r + CW'(1);
          end else begin
            burst_cnt_r <= burst_cnt_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          grant_r     <= '0;
          burst_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/async_fifo_wr_arb.md
Name: async_fifo_wr_arb

Overview:
- Write-side arbiter for async_fifo. Shares the single write port among NUM_SRC requesters.
- Round-robin grant with bounded bursts; stalls on FIFO full.
- Lives entirely in the write clock domain.
- Drives async_fifo fifo_w_req_i/fifo_w_data_i and consumes fifo_w_full_o.

Parameters:
- DATA_WIDTH, 8: width of each source word and of the FIFO write data.
- NUM_SRC, 4: number of requesters, 2..8.
- BURST_LEN, 4: maximum accepted words per grant before forced rotation, >=1.

Ports:
- fifo_w_clk_i  in  1  write clock; all logic on posedge.
- rst_n_i  in  1  asynchronous, active-low reset.
- src_req_i  in  NUM_SRC  per-source valid; data held stable until acked.
- src_data_i  in  NUM_SRC*DATA_WIDTH  packed source data; source k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- src_ack_o  out  NUM_SRC  one-hot accept strobe; a word transfers when src_req_i[k] & src_ack_o[k].
- fifo_w_req_o  out  1  to async_fifo fifo_w_req_i.
- fifo_w_data_o  out  DATA_WIDTH  to async_fifo fifo_w_data_i.
- fifo_w_full_i  in  1  from async_fifo fifo_w_full_o.
- grant_o  out  NUM_SRC  one-hot current owner; 0 when idle.
- busy_o  out  1  high in GRANT state.

Behaviour:
- Reset values:
  - state=IDLE, grant=0, last_grant index=NUM_SRC-1 (so source 0 wins first), burst_cnt=0.
  - All outputs 0.
- Datapath is combinational from registered grant:
  - fifo_w_req_o = |(grant & src_req_i).
  - fifo_w_data_o = data of granted source (0 when no grant).
  - src_ack_o = grant & src_req_i & {NUM_SRC{~fifo_w_full_i}}.
- Write event: wr = fifo_w_req_o & ~fifo_w_full_i. Exactly one FIFO write per wr cycle; none when full.
- IDLE:
  - If |src_req_i, grant the first requesting index after last_grant (modulo NUM_SRC).
  - Registered; first write possible the cycle after the request is seen (1-cycle latency).
  - Set burst_cnt=0 and go to GRANT.
- GRANT, burst_cnt counts wr events (width clog2(BURST_LEN+1)). The burst ends when either:
  - wr occurs and burst_cnt==BURST_LEN-1, or
  - src_req_i[owner]==0.
- At burst end:
  - last_grant <= owner.
  - If any other source (or the owner, when it is the only requester) requests, grant passes directly to the next round-robin requester with no bubble, burst_cnt=0.
  - Otherwise go to IDLE with grant=0.
- Full stall: while fifo_w_full_i=1 in GRANT:
  - Grant is held, burst_cnt is frozen, no ack is issued.
  - Stall length is unbounded; rotation never occurs due to full.
- Owner drops request mid-burst: the burst ends that cycle, no write, rotation as above.
- Simultaneous requests: pure round-robin from last_grant; no fixed priority beyond reset start point.
- BURST_LEN=1: rotate after every accepted word.
- Asynchronous reset mid-burst:
  - All state and outputs clear immediately.
  - An in-flight word that was not acked is not written.
  - Sources must re-present their data.
- Non-owner sources never see ack; their data is ignored.
- Invariants: grant_o is one-hot or zero; src_ack_o is a subset of grant_o; fifo_w_req_o never asserts in IDLE.

Decomposition:
- Shared package async_fifo_pkg:
  - clog2 function.
  - State encoding constants ST_IDLE/ST_GRANT.
  - Default DATA_WIDTH.
- One natural sub-module: rr_pick, a combinational round-robin selector.
  - Inputs: req vector, last index.
  - Outputs: one-hot grant, index, any.
  - Reused later for the read-side scheduler.
- Burst counter and FSM stay in the top module.

Test Plan:
- Single source: after reset, src_req_i=4'b0001 with data 0x10..0x17 for 8 words, FIFO not full.
  - Grant 0001 one cycle after req.
  - 8 FIFO writes in order; one bubble-free regrant of source 0 after word 4.
- All four requesting continuously, BURST_LEN=4.
  - Grant order 0,1,2,3,0, exactly 4 writes each.
  - No idle cycle between bursts; FIFO contents are source-tagged data in that order.
- Full stall: hold fifo_w_full_i=1 for 10 cycles after source 1's 2nd word.
  - No acks or writes during the stall; grant stays 0010.
  - After release, exactly 2 more words from source 1, then rotate to 2.
- Owner drop: source 2 deasserts after 1 word, sources 0 and 3 requesting.
  - Grant moves to 3 (next after 2) the following cycle.
  - Source 2's burst_cnt does not carry over.
- Reset mid-burst: assert rst_n_i low during source 3's 3rd word.
  - grant_o, src_ack_o, fifo_w_req_o go to 0 immediately.
  - After release, with all requesting, source 0 is granted first.
- Integrated with async_fifo (DATA_WIDTH 8, ADDR_DEPTY_BIT 9, write clk 20 ns, read clk 16 ns).
  - Fill to full with 4 sources, then drain.
  - The read sequence matches the scoreboard exactly; no word is lost or duplicated.
